// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell and a borrow flop
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN;
// otherwise ovf is tied low and no overflow flop exists.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, busy_q, done_q, bout_q;
    logic             diff_d, br_d, last;
    logic [WIDTH-1:0] r_d;

    // full-subtractor cell on the current LSBs of the operand shift registers
    always_comb begin
        diff_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        r_d    = {diff_d, r_q[WIDTH-1:1]};
        last   = cnt_q == CW'(WIDTH - 1);
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // control FSM and serial datapath; at the last bit a_q[0]/b_q[0] hold the operand MSBs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= r_d;
                    br_q  <= br_d;
                    cnt_q <= last ? cnt_q : cnt_q + 1'b1;
                    if (last) begin
                        d_q     <= r_d;
                        bout_q  <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_q   <= (a_q[0] ^ b_q[0]) & (diff_d ^ a_q[0]);
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for the WIDTH=8 bit-serial subtractor
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst, start, busy, done, bout, ovf;
    logic [7:0] a, b, d;
    logic [7:0] prev_d;
    int         n_checks = 0;
    int         n_fail   = 0;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one transaction; operands are corrupted right after accept to prove they were latched
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;
        check("busy_on", {31'd0, busy}, 1);
        check("d_hold", {24'd0, d}, {24'd0, prev_d});
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 8);
        check("d", {24'd0, d}, {24'd0, ed});
        check("bout", {31'd0, bout}, {31'd0, eb});
        check("ovf", {31'd0, ovf}, {31'd0, eo & OVF_EN});
        prev_d = ed;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 0);
        check("busy_off", {31'd0, busy}, 0);
    endtask

    initial begin
        int pulses, t_last;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; prev_d = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_d", {24'd0, d}, 0);
        check("rst_bout", {31'd0, bout}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        rst = 1'b0;

        run_op(8'd100, 8'd37, 8'd63,  1'b0, 1'b0);
        run_op(8'd5,   8'd9,  8'hFC,  1'b1, 1'b0);
        run_op(8'h80,  8'h01, 8'h7F,  1'b0, 1'b1);

        // start held high with a/b disturbed whenever busy
        @(negedge clk);
        a = 8'hA5; b = 8'hA5; start = 1'b1;
        pulses = 0; t_last = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (busy) begin a = 8'h3C; b = 8'hC1; end
            else begin a = 8'hA5; b = 8'hA5; end
            if (done) begin
                check("held_d", {24'd0, d}, 0);
                check("held_bout", {31'd0, bout}, 0);
                if (pulses > 0) check("held_period", k - t_last, 10);
                pulses++;
                t_last = k;
            end
        end
        check("held_pulses", pulses, 3);
        start = 1'b0;
        repeat (12) @(negedge clk);
        prev_d = 8'h00;

        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);

        // asynchronous reset three cycles into BUSY
        @(negedge clk);
        a = 8'd100; b = 8'd37; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_d", {24'd0, d}, 0);
        check("abort_bout", {31'd0, bout}, 0);
        prev_d = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
